// File: rtl/ddr_read_port.sv
// Read-side client for the shared local bus: issues credit-limited pipelined reads of a
// contiguous word run and streams the returned words out through a show-ahead FIFO.
module ddr_read_port #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic [ADDR_W-1:0] local_addr,
  output logic              local_read_req,
  input  logic              local_ready,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  issue_cnt_reg, rx_cnt_reg;
  logic [CNT_W-1:0]  inflight_reg, fifo_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic             start_ok, credit_ok, accept, pop, beat_ok;
  logic             fifo_empty, fifo_full, drained;
  logic [CNT_W:0]   credit_sum;

  assign start_ok   = cmd_start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign fifo_empty = (fifo_count_reg == '0);
  assign fifo_full  = (fifo_count_reg == FULL_CNT);
  assign pop        = !fifo_empty && out_ready;
  // Words on the bus plus words buffered must always fit, so no returned beat is ever dropped.
  assign credit_sum = {1'b0, inflight_reg} + {1'b0, fifo_count_reg} + (CNT_W+1)'(1);
  assign credit_ok  = credit_sum < {1'b0, FULL_CNT};
  assign accept     = local_read_req && local_ready;
  assign beat_ok    = local_rdata_valid && cmd_busy && (rx_cnt_reg != '0) &&
                      (inflight_reg != '0) && (!fifo_full || pop);
  // Leave DRAIN in the same cycle the final word is popped.
  assign drained    = (rx_cnt_reg == '0) &&
                      (fifo_empty || (fifo_count_reg == CNT_W'(1) && pop));

  assign local_addr = addr_reg;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (start_ok) state_next = (cmd_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: if (accept && issue_cnt_reg == LEN_W'(1)) state_next = S_DRAIN;
      S_DRAIN: if (drained) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_busy       = 1'b0;
    cmd_done       = 1'b0;
    local_read_req = 1'b0;
    case (state_reg)
      S_ISSUE: begin
        cmd_busy       = 1'b1;
        local_read_req = (issue_cnt_reg != '0) && credit_ok;
      end
      S_DRAIN: cmd_busy = 1'b1;
      S_DONE:  cmd_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_reg       <= '0;
      issue_cnt_reg  <= '0;
      rx_cnt_reg     <= '0;
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      ovf_err        <= 1'b0;
    end else begin
      if (start_ok && cmd_len != '0) begin
        addr_reg      <= cmd_addr;
        issue_cnt_reg <= cmd_len;
        rx_cnt_reg    <= cmd_len;
      end else begin
        if (accept) begin
          addr_reg      <= addr_reg + ADDR_W'(1);
          issue_cnt_reg <= issue_cnt_reg - LEN_W'(1);
        end
        if (beat_ok) rx_cnt_reg <= rx_cnt_reg - LEN_W'(1);
      end

      case ({accept, beat_ok})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: ;
      endcase

      case ({beat_ok, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: ;
      endcase

      if (beat_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (local_rdata_valid && !beat_ok) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (beat_ok) fifo_mem[wr_ptr_reg] <= local_rdata;
  end

endmodule

// File: doc/ddr_read_port.md
# ddr_read_port

Read-side client for the shared SSRAM/DDR local bus. It is the counterpart of the HOG+SVM write port. On a command it fetches a contiguous run of 32-bit words from memory and issues pipelined Avalon-style reads, holding the address stable under waitrequest. Returned data is buffered in a small FIFO and presented as a valid/ready stream, for example to the VGA/display path or to a result-readback path. Outstanding reads are credit-limited by FIFO space, so returned data can never be dropped.

## Interface
- ADDR_W, 32, local bus word-address width
- DATA_W, 32, data word width
- LEN_W, 16, width of the transfer-length field
- FIFO_DEPTH, 16, return-data FIFO depth in words; power of two, ≥4
- sys_clk  in  1  single clock for all logic; the local bus runs in this domain
- sys_rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle pulse that starts a transfer; accepted only while cmd_busy=0
- cmd_addr  in  ADDR_W  first word address; sampled when cmd_start is accepted
- cmd_len  in  LEN_W  number of words to read; sampled when cmd_start is accepted
- cmd_busy  out  1  transfer in progress
- cmd_done  out  1  one-cycle pulse when the transfer has completed
- local_addr  out  ADDR_W  read word address
- local_read_req  out  1  read request
- local_ready  in  1  request accepted this cycle (!waitrequest)
- local_rdata  in  DATA_W  read data
- local_rdata_valid  in  1  local_rdata is valid
- out_data  out  DATA_W  stream data (show-ahead FIFO head)
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- ovf_err  out  1  sticky: rdata arrived while the FIFO was full; cleared only by reset

## Operation
- Reset values: cmd_busy=0, cmd_done=0, local_read_req=0, local_addr=0, out_valid=0, out_data=0, ovf_err=0. The FIFO is empty, all counters are 0, and the FSM is in IDLE.
- FSM states:
  - IDLE: on cmd_start with cmd_len≠0, latch addr/len, set issue_cnt=len and rx_cnt=len, go to ISSUE. On cmd_start with cmd_len=0, go to DONE with no bus reads.
  - ISSUE: issue reads while issue_cnt≠0. When the last request is accepted, go to DRAIN.
  - DRAIN: wait until rx_cnt=0 and the FIFO is empty, then go to DONE.
  - DONE: pulse cmd_done for one cycle, go to IDLE.
- Credit rule: in-flight = requests accepted minus rdata_valid beats received.
  - A request may be asserted only if in-flight + fifo_count + (1 if a request is accepted this cycle) < FIFO_DEPTH.
  - A pop in the same cycle does not free credit until the next cycle; this is conservative.
- Request handshake:
  - local_read_req and local_addr stay constant until local_ready=1.
  - On acceptance, local_addr increments by 1 and issue_cnt decrements by 1.
  - local_read_req may stay high in back-to-back cycles, one read per accepted cycle.
  - The address wraps modulo 2^ADDR_W without error.
- Return path:
  - Each local_rdata_valid beat writes local_rdata into the FIFO and decrements rx_cnt.
  - A local_rdata_valid beat while not busy, or with the FIFO full, is discarded and sets ovf_err.
- Output: out_valid = FIFO not empty. A pop occurs when out_valid && out_ready. A simultaneous FIFO write and pop is legal, including when the FIFO is full.
- cmd_start while cmd_busy=1 is ignored and has no side effect.
- cmd_busy=1 in ISSUE and DRAIN; it is 0 in IDLE and DONE.
- Reset mid-transfer aborts immediately:
  - The FIFO and counters clear and local_read_req drops.
  - Late rdata beats arriving after reset release are discarded and set ovf_err.
  - Software must quiesce the bus before reset if this matters.

## Timing
- cmd_start accepted in cycle 0 → local_read_req=1 with local_addr=cmd_addr in cycle 1.
- With local_ready held at 1 and enough credit, accepted reads occur in cycles 1..len with no gaps.
- local_rdata_valid in cycle n → out_valid=1 with that word in cycle n+1 (registered FIFO write, show-ahead read).
- Pop in cycle p → the next word appears on out_data in cycle p+1 if available.
- Last word popped in cycle p → FSM is in DONE with cmd_done=1 and cmd_busy=0 in cycle p+1 → IDLE in cycle p+2. A new cmd_start is accepted from cycle p+1.
- cmd_len=0: cmd_start in cycle 0 → cmd_done=1 in cycle 1.
- Output words appear in request order; the bus returns data in order.

## Test plan
- Basic transfer:
  - Stimulus: cmd_addr=0x100, cmd_len=4, local_ready=1, read latency 3 cycles, out_ready=1.
  - Response: reads to 0x100..0x103 in cycles 1–4; out_valid in cycles 5–8 with data D0..D3 in order; cmd_done in cycle 9.
- Backpressure/credit:
  - Stimulus: FIFO_DEPTH=16, cmd_len=40, out_ready=0.
  - Response: exactly 15 requests accepted, then local_read_req=0 with no ovf_err.
  - Then release out_ready=1 → all 40 words are delivered in order and cmd_done pulses once.
- Waitrequest:
  - Stimulus: local_ready toggles 0/1 every cycle, cmd_len=5.
  - Response: local_addr is held during every ready=0 cycle; exactly 5 reads are accepted with no duplicate addresses.
- Edge commands:
  - Stimulus: cmd_len=0.
  - Response: cmd_done in cycle 1 and no local_read_req.
  - Stimulus: cmd_addr=0xFFFFFFFE, cmd_len=4.
  - Response: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - Stimulus: cmd_start while busy.
  - Response: ignored; the active transfer's addresses and length are unchanged.
- Reset abort:
  - Stimulus: assert sys_rst in the middle of a 20-word transfer.
  - Response: all outputs go to reset values immediately.
  - Then inject one stray local_rdata_valid → ovf_err=1 and out_valid stays 0.
